// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 format constants and types for the adder datapath
// (operand alignment and post-add normalization).
//   EXP_W/FRAC_W/EXP_BIAS/EXP_MAX : FP16 field geometry.
//   fp16_t                        : packed {sign, exp, frac} word.
//   norm_cls_e                    : special-case class decided before the shifter.
//   fp16_inf()/FP16_POS_ZERO      : canonical infinity and +0 encodings.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;
  localparam int FP16_W   = 1 + EXP_W + FRAC_W;

  // Mantissa with hidden bit, raw sum with carry bit, and guard/round/sticky.
  localparam int MANT_W   = FRAC_W + 1;
  localparam int SUM_W    = MANT_W + 1;
  localparam int GRS_W    = 3;
  localparam int NORM_W   = MANT_W + GRS_W;
  localparam int MANT_RW  = MANT_W + 1;
  // Adjusted exponent spans -11..32, so 7-bit signed never wraps.
  localparam int XEXP_W   = 7;
  localparam int LZC_W    = $clog2(MANT_W + 1);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_INF,
    CLS_ZERO,
    CLS_OVF,
    CLS_UF
  } norm_cls_e;

  localparam fp16_t FP16_POS_ZERO = '0;

  function automatic fp16_t fp16_inf(input logic sign);
    fp16_t f;
    f.sign = sign;
    f.exp  = '1;
    f.frac = '0;
    return f;
  endfunction

endpackage

// File: rtl/lzc_nbit.sv
// lzc_nbit: combinational leading-zero counter.
//   din   : N-bit input vector, MSB first.
//   count : number of zeros above the highest set bit; N when din is all zero.
module lzc_nbit #(
  parameter int N = 11,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     din,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = CNT_W'(N);
    // Scanning upward lets the highest set bit make the final assignment.
    for (int i = 0; i < N; i++) begin
      if (din[i]) count = CNT_W'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_normalize.sv
// fp16_normalize: post-add normalization and packing for the FP16 adder.
// Takes the raw mantissa sum (carry, hidden, fraction) plus guard/round/sticky,
// renormalizes it, adjusts the exponent and packs an FP16 word with
// overflow / flush-to-zero underflow / exact-zero flags.
// Two-stage valid/ready pipeline, one result per cycle, latency 2.
//   clk, rst                     : clock, synchronous active-high reset.
//   in_valid/in_ready            : input handshake.
//   in_sign, in_exp, in_sum, in_grs : sign, larger-operand exponent, raw sum, GRS.
//   out_valid/out_ready          : output handshake.
//   out_result                   : packed {sign, exp, frac}.
//   out_ovf, out_uf, out_zero    : overflow, flushed underflow, exact zero.
// Build option: define FP16_NORM_ROUND_EN for round-to-nearest-even;
// otherwise the post-shift guard/round/sticky bits are truncated.
module fp16_normalize
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic [GRS_W-1:0]  in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_result,
  output logic              out_ovf,
  output logic              out_uf,
  output logic              out_zero
);

  localparam logic signed [XEXP_W-1:0] EXP_MAX_X  = XEXP_W'(EXP_MAX);
  localparam logic signed [XEXP_W-1:0] EXP_ZERO_X = '0;

  // Mantissa rounding on the normalized {mant, g, r, s} vector. The result has
  // one extra MSB that catches a round carry out of an all-ones mantissa.
  function automatic logic [MANT_RW-1:0] round_mant(input logic [NORM_W-1:0] norm);
`ifdef FP16_NORM_ROUND_EN
    logic inc;
    inc = norm[GRS_W-1] & (norm[GRS_W-2] | norm[GRS_W-3] | norm[GRS_W]);
    return {1'b0, MANT_W'(norm >> GRS_W)} + MANT_RW'(inc);
`else
    return {1'b0, MANT_W'(norm >> GRS_W)};
`endif
  endfunction

  logic vld_p1, vld_p2;
  logic ld_p1, ld_p2;

  assign ld_p2     = !vld_p2 || out_ready;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign in_ready  = ld_p1;
  assign out_valid = vld_p2;

  // ---- Stage 0 -> 1: leading-zero count, exponent adjust, classification ----
  logic [LZC_W-1:0]          lzc_p0;
  logic signed [XEXP_W-1:0]  exp_adj_p0;
  norm_cls_e                 cls_p0;

  lzc_nbit #(.N(MANT_W)) u_lzc (
    .din   (in_sum[MANT_W-1:0]),
    .count (lzc_p0)
  );

  always_comb begin
    if (in_sum[SUM_W-1]) exp_adj_p0 = XEXP_W'(in_exp) + XEXP_W'(1);
    else                 exp_adj_p0 = XEXP_W'(in_exp) - XEXP_W'(lzc_p0);

    if (in_exp == EXP_W'(EXP_MAX))          cls_p0 = CLS_INF;
    else if (in_sum == '0 && in_grs == '0)  cls_p0 = CLS_ZERO;
    else if (exp_adj_p0 >= EXP_MAX_X)       cls_p0 = CLS_OVF;
    else if (exp_adj_p0 <= EXP_ZERO_X)      cls_p0 = CLS_UF;
    else                                    cls_p0 = CLS_NORM;
  end

  logic                      sign_p1;
  logic signed [XEXP_W-1:0]  exp_adj_p1;
  logic                      carry_p1;
  logic [LZC_W-1:0]          lzc_p1;
  logic [SUM_W-1:0]          sum_p1;
  logic [GRS_W-1:0]          grs_p1;
  norm_cls_e                 cls_p1;

  always_ff @(posedge clk) begin
    if (rst)        vld_p1 <= 1'b0;
    else if (ld_p1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (ld_p1 && in_valid) begin
      sign_p1    <= in_sign;
      exp_adj_p1 <= exp_adj_p0;
      carry_p1   <= in_sum[SUM_W-1];
      lzc_p1     <= lzc_p0;
      sum_p1     <= in_sum;
      grs_p1     <= in_grs;
      cls_p1     <= cls_p0;
    end
  end

  // ---- Stage 1 -> 2: shift, round, pack, flags ----
  logic [NORM_W-1:0]         norm;
  logic [MANT_RW-1:0]        mant_rnd;
  logic signed [XEXP_W-1:0]  exp_rnd;
  logic [FRAC_W-1:0]         frac;
  fp16_t                     res;
  logic                      ovf, uf, zero;

  always_comb begin
    // Carry: the bit shifted out becomes guard, old guard becomes round and
    // old round/sticky collapse into sticky.
    if (carry_p1) norm = {sum_p1[SUM_W-1:1], sum_p1[0], grs_p1[GRS_W-1], |grs_p1[GRS_W-2:0]};
    else          norm = {sum_p1[MANT_W-1:0], grs_p1} << lzc_p1;

    mant_rnd = round_mant(norm);
    exp_rnd  = exp_adj_p1 + XEXP_W'(mant_rnd[MANT_W]);
    frac     = mant_rnd[MANT_W] ? mant_rnd[FRAC_W:1] : mant_rnd[FRAC_W-1:0];

    res  = FP16_POS_ZERO;
    ovf  = 1'b0;
    uf   = 1'b0;
    zero = 1'b0;
    case (cls_p1)
      CLS_INF:  res = fp16_inf(sign_p1);
      CLS_ZERO: zero = 1'b1;
      CLS_OVF: begin
        res = fp16_inf(sign_p1);
        ovf = 1'b1;
      end
      CLS_UF:   uf = 1'b1;
      default: begin
        // A round carry can still push a normal result into infinity.
        if (exp_rnd >= EXP_MAX_X) begin
          res = fp16_inf(sign_p1);
          ovf = 1'b1;
        end else begin
          res.sign = sign_p1;
          res.exp  = exp_rnd[EXP_W-1:0];
          res.frac = frac;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_uf     <= 1'b0;
      out_zero   <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_result <= res;
        out_ovf    <= ovf;
        out_uf     <= uf;
        out_zero   <= zero;
      end
    end
  end

endmodule

// File: tb/tb_fp16_normalize.sv
`timescale 1ns/1ps
module tb_fp16_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_sum;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_uf;
  logic        out_zero;

  fp16_normalize dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_sum     (in_sum),
    .in_grs     (in_grs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_uf     (out_uf),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    logic        uf;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   gen_done;

`ifdef FP16_NORM_ROUND_EN
  localparam logic [15:0] RND_401 = 16'h3C02;
  localparam exp_t        RND_7FF = '{16'h7C00, 1'b1, 1'b0, 1'b0};
`else
  localparam logic [15:0] RND_401 = 16'h3C01;
  localparam exp_t        RND_7FF = '{16'h7BFF, 1'b0, 1'b0, 1'b0};
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, want);
    end
  endtask

  // Integer reference: normalize by repeated single-bit shifts.
  function automatic exp_t model(input logic s, input logic [4:0] e,
                                 input logic [11:0] sum, input logic [2:0] grs);
    exp_t r;
    int   m;
    int   ex;
    r = '0;
    if (e == 5'd31) begin
      r.res = {s, 5'h1F, 10'h000};
    end else if (sum == 12'h0 && grs == 3'h0) begin
      r.zero = 1'b1;
    end else begin
      m  = int'({sum, grs});
      ex = int'(e);
      if (m >= 16384) begin
        m  = (m >> 1) | (m & 1);
        ex = ex + 1;
      end
      while (m < 8192) begin
        m  = m << 1;
        ex = ex - 1;
      end
      if (ex >= 31) begin
        r.res = {s, 5'h1F, 10'h000};
        r.ovf = 1'b1;
      end else if (ex <= 0) begin
        r.uf = 1'b1;
      end else begin
`ifdef FP16_NORM_ROUND_EN
        if (m[2] && (m[1] || m[0] || m[3])) m = m + 8;
        if (m >= 16384) begin
          m  = m >> 1;
          ex = ex + 1;
        end
`endif
        if (ex >= 31) begin
          r.res = {s, 5'h1F, 10'h000};
          r.ovf = 1'b1;
        end else begin
          r.res = {s, ex[4:0], m[12:3]};
        end
      end
    end
    return r;
  endfunction

  task automatic send_beat(input logic s, input logic [4:0] e, input logic [11:0] sum,
                           input logic [2:0] grs, input exp_t want);
    int waited = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_sum   = sum;
    in_grs   = grs;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
      if (waited > 60) begin
        check_eq("in_ready_timeout", {31'h0, in_ready}, 32'h1);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) sb_q.push_back(want);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic s, input logic [4:0] e, input logic [11:0] sum,
                            input logic [2:0] grs);
    send_beat(s, e, sum, grs, model(s, e, sum, grs));
  endtask

  task automatic drain();
    int c = 0;
    while (sb_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    check_eq("drain_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output side of the scoreboard: every transfer pops one expectation.
  initial begin
    exp_t want;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_nonempty_on_out", sb_q.size(), 1);
        end else begin
          want = sb_q.pop_front();
          check_eq($sformatf("beat%0d", n_out),
                   {13'h0, out_result, out_ovf, out_uf, out_zero}, {13'h0, want});
        end
        n_out++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rs;
    logic [4:0]  re;
    logic [11:0] rsum;
    logic [2:0]  rgrs;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sum = '0; in_grs = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_eq("rst_out_result", {16'h0, out_result}, 32'h0);
    check_eq("rst_flags", {29'h0, out_ovf, out_uf, out_zero}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed vectors with hand-derived results.
    send_beat(1'b0, 5'd15, 12'h400, 3'b000, '{16'h3C00, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd15, 12'h800, 3'b000, '{16'h4000, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd30, 12'h800, 3'b000, '{16'h7C00, 1'b1, 1'b0, 1'b0});
    send_beat(1'b0, 5'd15, 12'h001, 3'b000, '{16'h1400, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd10, 12'h001, 3'b000, '{16'h0000, 1'b0, 1'b1, 1'b0});
    send_beat(1'b0, 5'd15, 12'h000, 3'b000, '{16'h0000, 1'b0, 1'b0, 1'b1});
    send_beat(1'b0, 5'd15, 12'h401, 3'b100, '{RND_401, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd15, 12'h400, 3'b100, '{16'h3C00, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd30, 12'h7FF, 3'b100, RND_7FF);
    send_beat(1'b1, 5'd31, 12'h5A5, 3'b011, '{16'hFC00, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd30, 12'h400, 3'b000, '{16'h7800, 1'b0, 1'b0, 1'b0});
    send_beat(1'b1, 5'd1,  12'h400, 3'b000, '{16'h8400, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd29, 12'h800, 3'b000, '{16'h7800, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd11, 12'h001, 3'b000, '{16'h0400, 1'b0, 1'b0, 1'b0});
    drain();

    // Backpressure: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    send_beat(1'b0, 5'd15, 12'h400, 3'b000, '{16'h3C00, 1'b0, 1'b0, 1'b0});
    send_beat(1'b0, 5'd16, 12'h800, 3'b000, '{16'h4400, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 5'd15; in_sum = 12'h001; in_grs = 3'b000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
      check_eq("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      check_eq("bp_hold_result", {13'h0, out_result, out_ovf, out_uf, out_zero},
               {13'h0, 16'h3C00, 3'b000});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_in_ready_high", {31'h0, in_ready}, 32'h1);
    if (in_ready) sb_q.push_back('{16'h9400, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(1'b0, 5'd20, 12'h400, 3'b000, '{16'h5000, 1'b0, 1'b0, 1'b0});
    send_beat(1'b1, 5'd20, 12'h800, 3'b000, '{16'hD400, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check_eq("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    check_eq("midrst_out_result", {16'h0, out_result}, 32'h0);
    rst = 1'b0;
    sb_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("post_rst_idle", {31'h0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Random beats against the model with random downstream stalls.
    gen_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rs   = 1'($urandom_range(0, 1));
          re   = 5'($urandom_range(0, 31));
          rsum = 12'($urandom_range(0, 4095)) >> $urandom_range(0, 11);
          rgrs = 3'($urandom_range(0, 7));
          if (rsum[10:0] == 11'h0 && !rsum[11]) rsum[0] = 1'b1;
          send_model(rs, re, rsum, rgrs);
        end
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
